// File: rtl/sun_pll_lock_pkg.sv
// Shared types and sizing helpers for the SUN_PLL lock controller.
// Latency: n/a (package). Backpressure: n/a.
package sun_pll_lock_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_PWRUP,
    ST_MEASURE,
    ST_LOCKED,
    ST_FAIL
  } lock_state_t;

  function automatic int calc_exp(input int win, input int fb_div);
    return win / fb_div;
  endfunction

  // Room for twice the nominal count so "too fast" still reads distinctly before saturation
  function automatic int calc_fcnt_w(input int win, input int fb_div);
    return $clog2(2 * calc_exp(win, fb_div) + 1);
  endfunction

  function automatic int calc_lo(input int win, input int fb_div, input int tol);
    int lo;
    lo = calc_exp(win, fb_div) - tol;
    return (lo < 0) ? 0 : lo;
  endfunction

  function automatic int calc_hi(input int win, input int fb_div, input int tol);
    return calc_exp(win, fb_div) + tol;
  endfunction

endpackage

// File: rtl/sun_pll_lock_fcnt.sv
// Synchronises FB_SLOW into CK and counts its rising edges over one measurement window.
// Latency: 3-flop sync + edge detect; win_cnt includes the rise of the current cycle.
// Backpressure: none; counter clears when disabled or at window close.
module sun_pll_lock_fcnt #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fb_slow,
  input  logic         cnt_en,
  input  logic         win_close,
  output logic [W-1:0] win_cnt
);

  logic         s1;
  logic         s2;
  logic         s3;
  logic         rise;
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= fb_slow;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Saturates so a runaway feedback clock still lands outside the tolerance band
  assign win_cnt = (rise && (cnt_q != {W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!cnt_en || win_close) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= win_cnt;
    end
  end

endmodule

// File: rtl/sun_pll_lock_ctrl.sv
// PLL start-up sequencer and lock detector; optional debug taps under SUN_PLL_LOCK_DBG_EN.
// Latency: all outputs registered, valid one CK after the deciding edge.
// Backpressure: none; EN low returns to OFF on the next cycle from any state.
module sun_pll_lock_ctrl
  import sun_pll_lock_pkg::*;
#(
  parameter int WIN      = 256,
  parameter int FB_DIV   = 8,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4,
  parameter int STARTUP  = 64,
  parameter int TIMEOUT  = 32
) (
  input  logic CK,
  input  logic RN,
  input  logic EN,
  input  logic FB_SLOW,
  output logic PWRUP_1V8,
  output logic LOCKED,
  output logic ERR
`ifdef SUN_PLL_LOCK_DBG_EN
  ,
  output logic [calc_fcnt_w(WIN, FB_DIV)-1:0] FCNT_LAST,
  output logic [7:0]                          UNLOCK_CNT
`endif
);

  localparam int FW = calc_fcnt_w(WIN, FB_DIV);
  localparam int PW = $clog2(WIN);
  localparam int SW = $clog2(STARTUP + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] CNT_LO = FW'(calc_lo(WIN, FB_DIV, TOL));
  localparam logic [FW-1:0] CNT_HI = FW'(calc_hi(WIN, FB_DIV, TOL));

  lock_state_t   state_q, state_d;
  logic [SW-1:0] dwell_q, dwell_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [GW-1:0] good_q, good_d;
  logic [GW-1:0] good_inc;
  logic [TW-1:0] wins_q, wins_d;
  logic          pwrup_q, locked_q, err_q;
  logic [FW-1:0] fcnt_now;
  logic          measuring;
  logic          win_end;
  logic          win_good;

  assign measuring = (state_q == ST_MEASURE) || (state_q == ST_LOCKED);
  assign win_end   = measuring && (pos_q == PW'(WIN - 1));
  assign win_good  = (fcnt_now >= CNT_LO) && (fcnt_now <= CNT_HI);
  assign good_inc  = good_q + 1'b1;

  sun_pll_lock_fcnt #(
    .W (FW)
  ) u_fcnt (
    .clk       (CK),
    .rst_n     (RN),
    .fb_slow   (FB_SLOW),
    .cnt_en    (EN && measuring),
    .win_close (win_end),
    .win_cnt   (fcnt_now)
  );

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    pos_d   = pos_q;
    good_d  = good_q;
    wins_d  = wins_q;
    if (!EN) begin
      state_d = ST_OFF;
      dwell_d = '0;
      pos_d   = '0;
      good_d  = '0;
      wins_d  = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_PWRUP;
          dwell_d = '0;
        end
        ST_PWRUP: begin
          if (dwell_q == SW'(STARTUP - 1)) begin
            state_d = ST_MEASURE;
            pos_d   = '0;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        ST_MEASURE: begin
          // Timeout is judged on the registered window count, one cycle after the last close
          if (wins_q == TW'(TIMEOUT)) begin
            state_d = ST_FAIL;
          end else begin
            pos_d = pos_q + 1'b1;
            if (win_end) begin
              wins_d = wins_q + 1'b1;
              if (win_good) begin
                good_d = good_inc;
                if (good_inc == GW'(LOCK_CNT)) begin
                  state_d = ST_LOCKED;
                end
              end else begin
                good_d = '0;
              end
            end
          end
        end
        ST_LOCKED: begin
          pos_d = pos_q + 1'b1;
          if (win_end && !win_good) begin
            state_d = ST_MEASURE;
            good_d  = '0;
            wins_d  = '0;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q  <= ST_OFF;
      dwell_q  <= '0;
      pos_q    <= '0;
      good_q   <= '0;
      wins_q   <= '0;
      pwrup_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      pos_q    <= pos_d;
      good_q   <= good_d;
      wins_q   <= wins_d;
      pwrup_q  <= (state_d != ST_OFF);
      locked_q <= (state_d == ST_LOCKED);
      err_q    <= (state_d == ST_FAIL);
    end
  end

  assign PWRUP_1V8 = pwrup_q;
  assign LOCKED    = locked_q;
  assign ERR       = err_q;

`ifdef SUN_PLL_LOCK_DBG_EN
  logic [FW-1:0] fcnt_last_q;
  logic [7:0]    unlock_cnt_q;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      fcnt_last_q  <= '0;
      unlock_cnt_q <= '0;
    end else begin
      if (EN && win_end) begin
        fcnt_last_q <= fcnt_now;
      end
      if (!EN) begin
        unlock_cnt_q <= '0;
      end else if ((state_q == ST_LOCKED) && (state_d == ST_MEASURE) && (unlock_cnt_q != 8'hFF)) begin
        unlock_cnt_q <= unlock_cnt_q + 1'b1;
      end
    end
  end

  assign FCNT_LAST  = fcnt_last_q;
  assign UNLOCK_CNT = unlock_cnt_q;
`endif

endmodule

// File: tb/tb_sun_pll_lock_ctrl.sv
// Directed bench for sun_pll_lock_ctrl with a cycle-level behavioural model and literal timing checks.
module tb_sun_pll_lock_ctrl;

  localparam int WIN      = 256;
  localparam int EXP      = 32;
  localparam int TOL      = 2;
  localparam int LOCK_CNT = 4;
  localparam int STARTUP  = 64;
  localparam int TIMEOUT  = 32;
  localparam int FMAX     = 127;

  logic CK = 1'b0;
  logic RN = 1'b0;
  logic EN = 1'b0;
  logic FB_SLOW = 1'b0;
  logic PWRUP_1V8, LOCKED, ERR;
`ifdef SUN_PLL_LOCK_DBG_EN
  logic [6:0] FCNT_LAST;
  logic [7:0] UNLOCK_CNT;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int e0 = 0;

  // Feedback pattern: exactly fb_n rises in every 256 consecutive CK cycles
  int fb_n = 32;
  bit fb_stuck = 1'b0;
  bit fb_level = 1'b0;
  int fb_restart = 0;
  int fb_seen = 0;
  int g = 0;

  sun_pll_lock_ctrl dut (
    .CK        (CK),
    .RN        (RN),
    .EN        (EN),
    .FB_SLOW   (FB_SLOW),
    .PWRUP_1V8 (PWRUP_1V8),
    .LOCKED    (LOCKED),
    .ERR       (ERR)
`ifdef SUN_PLL_LOCK_DBG_EN
    ,
    .FCNT_LAST (FCNT_LAST),
    .UNLOCK_CNT(UNLOCK_CNT)
`endif
  );

  always #5 CK = ~CK;

  always @(posedge CK) cyc <= cyc + 1;

  always @(negedge CK) begin
    if (fb_seen != fb_restart) begin
      g = 0;
      fb_seen = fb_restart;
    end
    if (fb_stuck) FB_SLOW = fb_level;
    else          FB_SLOW = ((g * fb_n) % 256) < 128;
    g = g + 1;
  end

  function automatic int cnow();
    return cyc - e0 + 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cnow());
    end
  endtask

  // Model: mode 0 idle, 1 powering up, 2 measuring, 3 failed
  int m_mode, m_age, m_pos, m_cnt, m_goods, m_wins, m_last, m_unl, m_rise;
  bit m_lock, m_good;
  bit [3:0] m_smp;

  always @(posedge CK or negedge RN) begin
    if (!RN) begin
      m_mode = 0; m_age = 0; m_pos = 0; m_cnt = 0; m_goods = 0;
      m_wins = 0; m_last = 0; m_unl = 0; m_lock = 1'b0; m_smp = '0;
    end else begin
      m_smp  = {m_smp[2:0], FB_SLOW};
      m_rise = (m_smp[2] && !m_smp[3]) ? 1 : 0;
      if (!EN) begin
        m_mode = 0; m_age = 0; m_pos = 0; m_cnt = 0; m_goods = 0;
        m_wins = 0; m_unl = 0; m_lock = 1'b0;
      end else if (m_mode == 0) begin
        m_mode = 1;
        m_age = 0;
      end else if (m_mode == 1) begin
        m_age++;
        if (m_age == STARTUP) begin
          m_mode = 2; m_pos = 0; m_cnt = 0;
        end
      end else if (m_mode == 2) begin
        if (!m_lock && m_wins == TIMEOUT) begin
          m_mode = 3;
        end else begin
          m_cnt = (m_cnt + m_rise > FMAX) ? FMAX : m_cnt + m_rise;
          if (m_pos == WIN - 1) begin
            m_good = (m_cnt >= EXP - TOL) && (m_cnt <= EXP + TOL);
            m_last = m_cnt;
            m_cnt  = 0;
            if (m_lock) begin
              if (!m_good) begin
                m_lock = 1'b0; m_goods = 0; m_wins = 0;
                if (m_unl < 255) m_unl++;
              end
            end else begin
              m_wins++;
              if (m_good) begin
                m_goods++;
                if (m_goods == LOCK_CNT) m_lock = 1'b1;
              end else begin
                m_goods = 0;
              end
            end
          end
          m_pos = (m_pos + 1) % WIN;
        end
      end
    end
  end

  always @(negedge CK) begin
    if (RN) begin
      chk("model_pwrup", 32'(PWRUP_1V8), 32'(m_mode != 0));
      chk("model_locked", 32'(LOCKED), 32'(m_lock));
      chk("model_err", 32'(ERR), 32'(m_mode == 3));
`ifdef SUN_PLL_LOCK_DBG_EN
      chk("model_fcnt_last", 32'(FCNT_LAST), 32'(m_last));
      chk("model_unlock_cnt", 32'(UNLOCK_CNT), 32'(m_unl));
`endif
    end
  end

  task automatic step();
    @(negedge CK);
  endtask

  task automatic enable();
    EN = 1'b1;
    e0 = cyc + 1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pwrup"}, 32'(PWRUP_1V8), 0);
    chk({tag, "_locked"}, 32'(LOCKED), 0);
    chk({tag, "_err"}, 32'(ERR), 0);
  endtask

  // which: 0 = LOCKED, 1 = ERR; at = -1 if the level never appears within maxc cycles
  task automatic wait_sig(input int which, input logic level, input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge CK);
      if (((which == 0) ? LOCKED : ERR) === level) begin
        at = cnow();
        break;
      end
    end
  endtask

  initial begin
    int at;
    int base;

    repeat (3) step();
    chk_zero("reset");
    RN = 1'b1;

    // Nominal lock
    fb_n = 32;
    enable();
    step();
    chk("pwrup_at_cycle1", 32'(PWRUP_1V8), 1);
    chk("locked_at_cycle1", 32'(LOCKED), 0);
    wait_sig(0, 1'b1, 1200, at);
    chk("lock_nominal_cycle", at, 1089);
    chk("err_after_lock", 32'(ERR), 0);

    // Loss of lock for one window, then recovery
    fb_stuck = 1'b1; fb_level = 1'b0;
    wait_sig(0, 1'b0, 300, at);
    chk("unlock_cycle", at, 1345);
    fb_stuck = 1'b0; fb_restart++;
    wait_sig(0, 1'b1, 1100, at);
    chk("relock_cycle", at, 2369);

    // EN drop while locked, then upper-tolerance lock at 34 edges
    EN = 1'b0;
    step();
    chk_zero("en_drop_locked");
    fb_n = 34;
    enable();
    wait_sig(0, 1'b1, 1200, at);
    chk("lock_34_cycle", at, 1089);

    // 35 edges: EN drop mid-MEASURE, then timeout into FAIL
    EN = 1'b0;
    step();
    fb_n = 35;
    enable();
    while (cnow() < 200) step();
    chk("pwrup_mid_measure", 32'(PWRUP_1V8), 1);
    EN = 1'b0;
    step();
    chk_zero("en_drop_measure");
    enable();
    wait_sig(1, 1'b1, 8400, at);
    chk("err_35_cycle", at, 8258);
    chk("fail_pwrup", 32'(PWRUP_1V8), 1);
    chk("fail_locked", 32'(LOCKED), 0);
    repeat (5) step();
    chk("fail_err_sticky", 32'(ERR), 1);
    EN = 1'b0;
    step();
    chk_zero("en_drop_fail");

    // Saturating (too fast) windows, stuck-high windows, then nominal
    fb_n = 128;
    enable();
    while (cnow() < 833) step();
    fb_stuck = 1'b1; fb_level = 1'b1;
    while (cnow() < 1345) step();
    fb_stuck = 1'b0; fb_n = 32; fb_restart++;
    wait_sig(0, 1'b1, 1100, at);
    chk("lock_after_bad_cycle", at, 2369);
`ifdef SUN_PLL_LOCK_DBG_EN
    chk("dbg_fcnt_last_nominal", 32'(FCNT_LAST), 32);
`endif

    // Three forced unlock/relock events
    base = 2369;
    for (int k = 0; k < 3; k++) begin
      fb_stuck = 1'b1; fb_level = 1'b0;
      wait_sig(0, 1'b0, 300, at);
      chk("repeat_unlock_cycle", at, base + 256);
      fb_stuck = 1'b0; fb_restart++;
      wait_sig(0, 1'b1, 1100, at);
      chk("repeat_relock_cycle", at, base + 1280);
      base = base + 1280;
    end
`ifdef SUN_PLL_LOCK_DBG_EN
    chk("dbg_unlock_cnt_3", 32'(UNLOCK_CNT), 3);
`endif

    // Asynchronous reset pulse while locked, EN held high
    repeat (10) step();
    #2 RN = 1'b0;
    #1 chk_zero("async_reset");
    #1 RN = 1'b1;
    e0 = cyc + 1;
    step();
    chk("pwrup_after_reset", 32'(PWRUP_1V8), 1);
    wait_sig(0, 1'b1, 1200, at);
    chk("lock_after_reset_cycle", at, 1089);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sun_pll_lock_ctrl.md
Name: sun_pll_lock_ctrl

Overview:
- Digital start-up sequencer and lock detector for the SUN_PLL analog core; it drives the PLL and consumes its feedback clock.
- Drives PWRUP_1V8 to the PLL, waits a settling time, then counts edges of the divided feedback clock over reference-clock windows.
- Asserts LOCKED after consecutive in-tolerance windows, drops it on a bad window, and flags ERR if lock is not reached in time.
- Clocked by the PLL reference clock; sits in the digital domain next to the PLL macro.

Parameters:
- WIN, 256: reference cycles per measurement window (power of 2).
- FB_DIV, 8: division ratio of FB_SLOW relative to the PLL feedback clock; expected count EXP = WIN/FB_DIV = 32.
- TOL, 2: allowed |count − EXP|.
- LOCK_CNT, 4: consecutive good windows required for lock.
- STARTUP, 64: reference cycles PWRUP_1V8 is held before the first window.
- TIMEOUT, 32: windows allowed in MEASURE before ERR.

Ports:
- CK  in  1  reference clock (same net as the PLL CK_REF).
- RN  in  1  asynchronous active-low reset.
- EN  in  1  enable request, synchronous to CK.
- FB_SLOW  in  1  PLL feedback clock divided by FB_DIV; asynchronous to CK.
- PWRUP_1V8  out  1  PLL power-up; drives the PLL PWRUP_1V8.
- LOCKED  out  1  PLL lock status.
- ERR  out  1  lock timeout flag, sticky until EN goes low.

Behaviour:
- Reset, asynchronous on RN low: state OFF; PWRUP_1V8=0, LOCKED=0, ERR=0; all counters 0.
- FB_SLOW path:
  - 3-flop chain s1→s2→s3.
  - rise = s2 & ~s3.
  - Edge counter FCNT is $clog2(2*EXP+1) bits wide and saturates at all-ones.
- Window counter runs 0..WIN−1 in MEASURE and LOCKED. A window closes at count WIN−1.
  - The rise in the closing cycle is included in that window's count.
  - FCNT resets to 0 for the next window.
  - good = (FCNT within EXP−TOL .. EXP+TOL).
- FSM states: OFF, PWRUP, MEASURE, LOCKED, FAIL.
  - OFF: when EN is sampled high, go to PWRUP; PWRUP_1V8=1 from the next cycle.
  - PWRUP: dwell exactly STARTUP cycles, then MEASURE. The window counter starts at 0 on the first MEASURE cycle.
  - MEASURE, good window close: increment the good-run counter. If it reaches LOCK_CNT, go to LOCKED; LOCKED=1 from the next cycle.
  - MEASURE, bad window close: clear the good-run counter.
  - MEASURE timeout: a window counter counts closed windows. If it reaches TIMEOUT without lock, go to FAIL; ERR=1 from the next cycle.
  - LOCKED: keeps measuring. A bad window returns to MEASURE (LOCKED=0 next cycle) and clears the good-run and window counters, so the timeout restarts.
  - FAIL: PWRUP_1V8 stays 1, LOCKED=0, ERR=1; no further measurement.
- EN low in any state: go to OFF next cycle, with PWRUP_1V8=0, LOCKED=0, ERR=0 and counters cleared. This takes priority over any simultaneous window close.
- FB_SLOW stuck at either level gives count 0, which is a bad window.
- FB_SLOW too fast saturates FCNT, which is a bad window.
- All outputs are registered; no combinational path from input to output.

Optional Feature:
- Macro SUN_PLL_LOCK_DBG_EN.
- When defined, two extra output ports are added:
  - FCNT_LAST, FCNT width: count of the last closed window, updated at each window close, reset 0.
  - UNLOCK_CNT, 8 bits: saturating count of LOCKED→MEASURE transitions; cleared by reset or when EN goes low.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package sun_pll_lock_pkg holds:
  - state enum typedef (OFF, PWRUP, MEASURE, LOCKED, FAIL);
  - localparam function computing EXP and counter widths from WIN/FB_DIV/TOL.
- One sub-module, sun_pll_lock_fcnt: synchronizer, edge detect, saturating edge counter, clear-on-window-close.
- The FSM and window/timeout counters stay in the top module.

Test Plan:
- Nominal lock (defaults): EN rises, sampled at cycle 0; FB_SLOW period 8 CK → PWRUP_1V8=1 at cycle 1, LOCKED=1 at cycle 1089, ERR=0.
- Tolerance edge: FB_SLOW giving 34 edges per window → locks. Giving 35 per window → never locks; ERR=1 after 32 windows (cycle 1+64+32*256+1 = 8258).
- Loss of lock: after LOCKED, stop FB_SLOW for one window → LOCKED=0 one cycle after that window closes. Resume at 32/window → LOCKED=1 again after 4 more windows.
- EN drop mid-MEASURE and in FAIL: deassert EN → next cycle PWRUP_1V8=0, LOCKED=0, ERR=0. Re-enable → full sequence repeats with identical timing.
- Async reset mid-LOCKED: pulse RN low off-edge → outputs 0 immediately. After release with EN high → restart from PWRUP.
- SUN_PLL_LOCK_DBG_EN build: FCNT_LAST=32 after nominal windows. Three forced unlock events → UNLOCK_CNT=3. Saturation at 255.
